wvb_rd_ctrl: RTL and testbench

WVB_RD_CTRL -- requirements
Module: wvb_rd_ctrl

---
 rtl/wvb_rd_ctrl_if.sv | 37 +++
 rtl/wvb_rd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_wvb_rd_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wvb_rd_ctrl_if.sv
// Bus bundle for wvb_rd_ctrl: header FIFO, waveform buffer read port,
// sample stream and per-event sideband. master = controller, slave = environment.
interface wvb_rd_ctrl_if #(
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 160,
   parameter int P_LTC_WIDTH  = 48
);
   logic                    hdr_empty;
   logic [P_HDR_WIDTH-1:0]  hdr_data;
   logic                    hdr_rdreq;
   logic [P_ADR_WIDTH-1:0]  wvb_rd_addr;
   logic [P_DATA_WIDTH-1:0] wvb_data;
   logic [P_DATA_WIDTH-1:0] dout;
   logic                    dout_valid;
   logic                    dout_ready;
   logic                    dout_sot;
   logic                    dout_eoe;
   logic [P_LTC_WIDTH-1:0]  evt_ltc;
   logic [1:0]              evt_trig_src;
   logic                    evt_cnst_run;
   logic [P_ADR_WIDTH-1:0]  rd_done_addr;
   logic                    busy;
   logic [15:0]             evt_cnt;

   modport master (
      input  hdr_empty, hdr_data, wvb_data, dout_ready,
      output hdr_rdreq, wvb_rd_addr, dout, dout_valid, dout_sot, dout_eoe,
             evt_ltc, evt_trig_src, evt_cnst_run, rd_done_addr, busy, evt_cnt
   );

   modport slave (
      output hdr_empty, hdr_data, wvb_data, dout_ready,
      input  hdr_rdreq, wvb_rd_addr, dout, dout_valid, dout_sot, dout_eoe,
             evt_ltc, evt_trig_src, evt_cnst_run, rd_done_addr, busy, evt_cnt
   );
endinterface

// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer read controller: pops one header per event and streams its samples
// through a 2-entry skid buffer. Optional macro WVB_RD_EVT_CNT_EN builds the event counter.
module wvb_rd_ctrl #(
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 160,
   parameter int P_LTC_WIDTH  = 48
) (
   input logic          clk,
   input logic          rst,
   wvb_rd_ctrl_if.master bus
);
   localparam int L_LTC_LSB  = 2 * P_ADR_WIDTH;
   localparam int L_TRIG_LSB = L_LTC_LSB + P_LTC_WIDTH;
   localparam int L_CNST_BIT = L_TRIG_LSB + 2;
   localparam logic [P_ADR_WIDTH-1:0] L_ADR_ONE = 1;
   localparam logic [P_ADR_WIDTH:0]   L_REM_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_FETCH, S_STREAM} state_t;

   typedef struct packed {
      logic [P_DATA_WIDTH-1:0] data;
      logic [P_ADR_WIDTH-1:0]  addr;
      logic                    sot;
      logic                    eoe;
   } beat_t;

   state_t                  state, state_nxt;
   logic [P_ADR_WIDTH-1:0]  rd_addr;
   logic [P_ADR_WIDTH:0]    rem;
   logic                    first;
   logic                    cap_vld, cap_sot, cap_eoe;
   logic [P_ADR_WIDTH-1:0]  cap_addr;
   beat_t                   head, tail, incoming;
   logic [1:0]              cnt, occ;
   logic                    pop, issue, load, hdr_rdreq, busy;
   logic [P_ADR_WIDTH-1:0]  hdr_start, hdr_stop, span, rd_done;
   logic [P_LTC_WIDTH-1:0]  ltc;
   logic [1:0]              trig;
   logic                    cnst;

   assign hdr_stop  = bus.hdr_data[P_ADR_WIDTH-1:0];
   assign hdr_start = bus.hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
   assign span      = hdr_stop - hdr_start + L_ADR_ONE;

   // Header fields are captured on the IDLE->HDR edge so they are already valid in S_HDR.
   assign load = (state == S_IDLE) && !bus.hdr_empty;
   assign pop  = (cnt != 2'd0) && bus.dout_ready;
   // Skid occupancy after this cycle, counting the read already in flight.
   assign occ  = cnt + {1'b0, cap_vld} - {1'b0, pop};
   assign incoming = '{data: bus.wvb_data, addr: cap_addr, sot: cap_sot, eoe: cap_eoe};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!bus.hdr_empty) state_nxt = S_HDR;
         S_HDR:    state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_STREAM;
         S_STREAM: if (pop && head.eoe) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      hdr_rdreq = 1'b0;
      busy      = 1'b1;
      issue     = (rem != '0) && (occ < 2'd2);
      case (state)
         S_IDLE: begin
            busy  = 1'b0;
            issue = 1'b0;
         end
         S_HDR:   hdr_rdreq = !bus.hdr_empty;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr  <= '0;
         rem      <= '0;
         first    <= 1'b0;
         cap_vld  <= 1'b0;
         cap_sot  <= 1'b0;
         cap_eoe  <= 1'b0;
         cap_addr <= '0;
         ltc      <= '0;
         trig     <= '0;
         cnst     <= 1'b0;
      end else begin
         cap_vld <= issue;
         if (load) begin
            rd_addr <= hdr_start;
            rem     <= (span == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}} : {1'b0, span};
            first   <= 1'b1;
            ltc     <= bus.hdr_data[L_LTC_LSB +: P_LTC_WIDTH];
            trig    <= bus.hdr_data[L_TRIG_LSB +: 2];
            cnst    <= bus.hdr_data[L_CNST_BIT];
         end else if (issue) begin
            rd_addr  <= rd_addr + L_ADR_ONE;
            rem      <= rem - L_REM_ONE;
            first    <= 1'b0;
            cap_sot  <= first;
            cap_eoe  <= (rem == L_REM_ONE);
            cap_addr <= rd_addr;
         end
      end
   end

   // NOTE: the skid entries are plain registers, so they take the async reset like any other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         cnt     <= 2'd0;
         rd_done <= '0;
      end else begin
         if (pop) rd_done <= head.addr;
         case ({cap_vld, pop})
            2'b10: begin
               if (cnt == 2'd0) head <= incoming;
               else             tail <= incoming;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               head <= tail;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  head <= incoming;
               end else begin
                  head <= tail;
                  tail <= incoming;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WVB_RD_EVT_CNT_EN
   logic [15:0] evt_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        evt_cnt_q <= '0;
      else if (pop && head.eoe && evt_cnt_q != 16'hFFFF) evt_cnt_q <= evt_cnt_q + 16'd1;
   end

   assign bus.evt_cnt = evt_cnt_q;
`else
   assign bus.evt_cnt = '0;
`endif

   generate
      if (P_HDR_WIDTH > L_CNST_BIT + 1) begin : g_hdr_spare
         logic unused_hdr_bits;
         assign unused_hdr_bits = ^bus.hdr_data[P_HDR_WIDTH-1:L_CNST_BIT+1];
      end
   endgenerate

   assign bus.hdr_rdreq    = hdr_rdreq;
   assign bus.wvb_rd_addr  = rd_addr;
   assign bus.dout         = head.data;
   assign bus.dout_valid   = (cnt != 2'd0);
   assign bus.dout_sot     = head.sot;
   assign bus.dout_eoe     = head.eoe;
   assign bus.evt_ltc      = ltc;
   assign bus.evt_trig_src = trig;
   assign bus.evt_cnst_run = cnst;
   assign bus.rd_done_addr = rd_done;
   assign bus.busy         = busy;
endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Self-checking bench for wvb_rd_ctrl: directed vector table, reset/back-to-back
// sequences and random traffic scored against a queue-based event model.
module tb_wvb_rd_ctrl;
   localparam int AW = 12;
   localparam int DW = 22;
   localparam int LW = 48;
   localparam int HW = 160;
`ifdef WVB_RD_EVT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          sot;
      logic          eoe;
      logic [LW-1:0] ltc;
      logic [1:0]    trig;
      logic          cnst;
   } beat_t;

   typedef struct {
      logic [AW-1:0] start;
      logic [AW-1:0] stop;
      logic [3:0]    rdy_pat;
      int            exp_beats;
      logic [AW-1:0] exp_last;
      int            exp_span;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wvb_rd_ctrl_if bus ();
   wvb_rd_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   logic [DW-1:0] mem [4096];
   beat_t         exp_q [$];
   logic [HW-1:0] hdr_q [$];

   int n_checks = 0, n_pass = 0;
   int cyc = 0, pops = 0, beats = 0, model_evts = 0;
   int first_beat_cyc = 0, last_beat_cyc = 0, last_eoe_cyc = 0, last_gap = 0;
   bit have_eoe = 1'b0, use_rand = 1'b0, stall_prev = 1'b0, beat_prev = 1'b0;
   logic [3:0]    rdy_pat = 4'hF;
   int            rdy_idx = 0;
   logic [DW-1:0] hold_dout;
   logic          hold_sot, hold_eoe;
   logic [AW-1:0] prev_addr;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model: an event is simply the address run start..stop modulo 4096.
   task automatic push_hdr(input logic [AW-1:0] start, input logic [AW-1:0] stop);
      logic [HW-1:0] h;
      logic [LW-1:0] ltc;
      logic [1:0]    trig;
      logic          cnst;
      int            n;
      for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
      ltc  = LW'({$urandom, $urandom});
      trig = 2'($urandom);
      cnst = 1'($urandom);
      h[AW-1:0]        = stop;
      h[2*AW-1:AW]     = start;
      h[2*AW +: LW]    = ltc;
      h[2*AW+LW +: 2]  = trig;
      h[2*AW+LW+2]     = cnst;
      n = ((int'(stop) - int'(start) + 4096) % 4096) + 1;
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.addr = AW'((int'(start) + i) % 4096);
         b.data = mem[b.addr];
         b.sot  = (i == 0);
         b.eoe  = (i == n - 1);
         b.ltc  = ltc;
         b.trig = trig;
         b.cnst = cnst;
         exp_q.push_back(b);
      end
      hdr_q.push_back(h);
      bus.hdr_empty = 1'b0;
      bus.hdr_data  = hdr_q[0];
   endtask

   // One clock: observe at negedge, then update the FIFO/buffer models just after posedge.
   task automatic cycle();
      logic          rdreq_s;
      logic [AW-1:0] addr_s;
      @(negedge clk);
      cyc++;
      rdreq_s = bus.hdr_rdreq;
      addr_s  = bus.wvb_rd_addr;
      if (beat_prev) check("rd_done_addr", bus.rd_done_addr, prev_addr);
      if (rdreq_s) begin
         pops++;
         check("rdreq_nonempty", bus.hdr_empty, 0);
      end
      if (stall_prev)
         check("hold_stalled", {bus.dout_valid, bus.dout, bus.dout_sot, bus.dout_eoe},
               {1'b1, hold_dout, hold_sot, hold_eoe});
      beat_prev  = 1'b0;
      stall_prev = 1'b0;
      if (bus.dout_valid && bus.dout_ready) begin
         check("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat", {bus.dout, bus.dout_sot, bus.dout_eoe, bus.evt_ltc, bus.evt_trig_src, bus.evt_cnst_run},
                  {e.data, e.sot, e.eoe, e.ltc, e.trig, e.cnst});
            prev_addr = e.addr;
            beats++;
            if (e.sot) begin
               first_beat_cyc = cyc;
               if (have_eoe) last_gap = cyc - last_eoe_cyc;
            end
            if (e.eoe) begin
               last_eoe_cyc = cyc;
               have_eoe     = 1'b1;
               model_evts++;
            end
            last_beat_cyc = cyc;
            beat_prev     = 1'b1;
         end
      end else if (bus.dout_valid) begin
         stall_prev = 1'b1;
         hold_dout  = bus.dout;
         hold_sot   = bus.dout_sot;
         hold_eoe   = bus.dout_eoe;
      end
      @(posedge clk);
      #1;
      if (rdreq_s && hdr_q.size() != 0) void'(hdr_q.pop_front());
      bus.wvb_data   = mem[addr_s];
      bus.hdr_empty  = (hdr_q.size() == 0);
      bus.hdr_data   = (hdr_q.size() != 0) ? hdr_q[0] : '0;
      bus.dout_ready = use_rand ? ($urandom_range(0, 3) != 0) : rdy_pat[rdy_idx % 4];
      rdy_idx++;
   endtask

   function automatic bit all_done();
      return exp_q.size() == 0 && hdr_q.size() == 0 && !bus.busy && !beat_prev;
   endfunction

   task automatic drain(input int budget);
      bit done;
      done = all_done();
      for (int i = 0; i < budget && !done; i++) begin
         cycle();
         done = all_done();
      end
      check("drain_in_budget", done, 1);
   endtask

   // Asserts rst between clock edges and checks the outputs clear with no edge in between.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_zero",
            {bus.hdr_rdreq, bus.dout_valid, bus.dout_sot, bus.dout_eoe, bus.busy, bus.wvb_rd_addr,
             bus.rd_done_addr, bus.dout, bus.evt_ltc, bus.evt_trig_src, bus.evt_cnst_run, bus.evt_cnt}, 0);
      exp_q.delete();
      hdr_q.delete();
      bus.hdr_empty = 1'b1;
      bus.hdr_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      stall_prev = 1'b0;
      beat_prev  = 1'b0;
      have_eoe   = 1'b0;
      model_evts = 0;
      pops       = 0;
      beats      = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs [5];
      int   pushed;
      vecs[0] = '{12'h010, 12'h013, 4'b1111, 4,    12'h013, 3};
      vecs[1] = '{12'hFFE, 12'h001, 4'b1111, 4,    12'h001, 3};
      vecs[2] = '{12'h200, 12'h200, 4'b1111, 1,    12'h200, 0};
      vecs[3] = '{12'h040, 12'h047, 4'b1001, 8,    12'h047, -1};
      vecs[4] = '{12'h123, 12'h122, 4'b1111, 4096, 12'h122, 4095};

      for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
      rst            = 1'b1;
      bus.hdr_empty  = 1'b1;
      bus.hdr_data   = '0;
      bus.wvb_data   = '0;
      bus.dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state",
            {bus.hdr_rdreq, bus.dout_valid, bus.dout_sot, bus.dout_eoe, bus.busy, bus.wvb_rd_addr,
             bus.rd_done_addr, bus.dout, bus.evt_ltc, bus.evt_trig_src, bus.evt_cnst_run, bus.evt_cnt}, 0);
      rst = 1'b0;

      foreach (vecs[v]) begin
         pops = 0;
         beats = 0;
         use_rand = 1'b0;
         rdy_pat = vecs[v].rdy_pat;
         bus.dout_ready = rdy_pat[0];
         rdy_idx = 1;
         push_hdr(vecs[v].start, vecs[v].stop);
         drain(vecs[v].exp_beats * 4 + 50);
         check("vec_beats", beats, vecs[v].exp_beats);
         check("vec_last_addr", bus.rd_done_addr, vecs[v].exp_last);
         check("vec_pops", pops, 1);
         check("vec_busy_idle", bus.busy, 0);
         if (vecs[v].exp_span >= 0) check("vec_span", last_beat_cyc - first_beat_cyc, vecs[v].exp_span);
         check("vec_evt_cnt", bus.evt_cnt, CNT_EN ? model_evts : 0);
      end

      // Two queued headers: at most 3 idle dout cycles between the eoe beat and the next sot beat.
      do_reset();
      rdy_pat = 4'hF;
      last_gap = 999;
      push_hdr(12'h100, 12'h104);
      push_hdr(12'h500, 12'h502);
      drain(100);
      check("b2b_gap", last_gap <= 4, 1);
      check("b2b_pops", pops, 2);
      check("b2b_evt_cnt", bus.evt_cnt, CNT_EN ? 2 : 0);

      // Reset while beat 3 of 6 is on the bus; the popped header must not come back.
      push_hdr(12'h300, 12'h305);
      beats = 0;
      pops = 0;
      for (int i = 0; i < 50 && beats < 2; i++) cycle();
      check("mid_reach_beat2", beats, 2);
      check("mid_pops", pops, 1);
      do_reset();
      repeat (5) cycle();
      check("mid_no_reread", pops, 0);
      check("mid_idle", bus.busy, 0);
      push_hdr(12'h7F0, 12'h7F3);
      drain(60);
      check("mid_restart_beats", beats, 4);
      check("mid_restart_last", bus.rd_done_addr, 12'h7F3);

      // Random headers and back-pressure against the queue model.
      do_reset();
      use_rand = 1'b1;
      pushed = 0;
      for (int i = 0; i < 20000 && !(pushed == 40 && all_done()); i++) begin
         if (pushed < 40 && $urandom_range(0, 5) == 0) begin
            logic [AW-1:0] start;
            int            len;
            start = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4080, 4095)) : AW'($urandom);
            len   = $urandom_range(1, 24);
            push_hdr(start, AW'(int'(start) + len - 1));
            pushed++;
         end
         cycle();
      end
      check("rand_complete", pushed == 40 && all_done(), 1);
      check("rand_pops", pops, 40);
      check("rand_evt_cnt", bus.evt_cnt, CNT_EN ? 40 : 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
